// File: rtl/tl_pkg.sv
// TileLink A-channel types and burst helpers shared by the arbiters.
// Opcode enum, A-beat struct, FSM state enum, beat-count functions.
package tl_pkg;

  localparam int TL_CNT_W = 16;

  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    ARITHMETIC_DATA  = 3'd2,
    LOGICAL_DATA     = 3'd3,
    GET              = 3'd4,
    INTENT           = 3'd5,
    ACQUIRE_BLOCK    = 3'd6,
    ACQUIRE_PERM     = 3'd7
  } tl_a_op_e;

  typedef struct packed {
    tl_a_op_e    opcode;
    logic [3:0]  size;
    logic [3:0]  source;
    logic [15:0] data;
  } tl_a_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  function automatic logic tl_is_data_op(
    input tl_a_op_e op
  );
    return (op == PUT_FULL_DATA)
        || (op == PUT_PARTIAL_DATA)
        || (op == ARITHMETIC_DATA)
        || (op == LOGICAL_DATA);
  endfunction

  // Beats for a data-carrying message of 2^size bytes, saturated.
  function automatic logic [TL_CNT_W-1:0] tl_beats(
    input logic [3:0] size,
    input int         beat_bytes,
    input int         max_beats
  );
    int bytes;
    int b;
    bytes = 1 << size;
    b = (bytes > beat_bytes) ? bytes / beat_bytes : 1;
    if (b > max_beats) b = max_beats;
    return TL_CNT_W'(b);
  endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Fixed-priority / round-robin one-hot selector.
// mode=0: lowest index wins; mode=1: first request at or after ptr.
module tl_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  int   c;
  logic found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    c          = 0;
    for (int k = 0; k < N; k++) begin
      c = mode ? (int'(ptr) + k) % N : k;
      if (!found && req[c]) begin
        found         = 1'b1;
        gnt_idx       = IDX_W'(c);
        gnt_onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_burst_arbiter.sv
// TileLink A-channel N:1 arbiter with multi-beat burst locking.
// Optional per-master stall counters: TL_BURST_ARB_STALL_CNT_EN.
module tl_burst_arbiter
  import tl_pkg::*;
#(
  parameter int  MASTER_NUM = 4,
  parameter type DATA_T     = tl_a_t,
  parameter int  BEAT_BYTES = 8,
  parameter int  MAX_BEATS  = 16,
  parameter int  ARB_MODE   = 1,
  localparam int IDX_W =
    (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
  localparam int CNT_W = $clog2(MAX_BEATS) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  DATA_T [MASTER_NUM-1:0]  inp_bits_i,
  input  logic  [MASTER_NUM-1:0]  inp_valid_i,
  output logic  [MASTER_NUM-1:0]  inp_ready_o,
  output DATA_T                   oup_bits_o,
  output logic                    oup_valid_o,
  input  logic                    oup_ready_i,
  output logic  [IDX_W-1:0]       grant_idx_o,
  output logic                    burst_lock_o
`ifdef TL_BURST_ARB_STALL_CNT_EN
  ,
  input  logic                    stall_clr_i,
  output logic [MASTER_NUM-1:0][15:0] stall_cnt_o
`endif
);

  localparam int SAT_SIZE = $clog2(MAX_BEATS * BEAT_BYTES);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, gnt_q, owner_q;
  logic [IDX_W-1:0] pick_idx, grant, rr_next;
  logic [CNT_W-1:0] remaining_q, beats;
  logic [MASTER_NUM-1:0] pick_oh;
  logic             hold_q, hs;

  tl_rr_picker #(
    .N     (MASTER_NUM),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (inp_valid_i),
    .ptr        (rr_ptr_q),
    .mode       (ARB_MODE == 1),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx)
  );

  always_comb begin
    if (state_q == ARB_BURST)
      grant = owner_q;
    else if (hold_q)
      grant = gnt_q;
    else
      grant = pick_idx;
    oup_bits_o  = inp_bits_i[grant];
    oup_valid_o = inp_valid_i[grant];
    hs          = oup_valid_o & oup_ready_i;
    beats       = tl_is_data_op(oup_bits_o.opcode)
      ? CNT_W'(tl_beats(oup_bits_o.size,
                        BEAT_BYTES, MAX_BEATS))
      : CNT_W'(1);
    rr_next = (grant == IDX_W'(MASTER_NUM - 1))
      ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:
        if (hs && beats > CNT_W'(1))
          state_d = ARB_BURST;
      ARB_BURST:
        if (hs && remaining_q == CNT_W'(1))
          state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    burst_lock_o       = (state_q == ARB_BURST);
    grant_idx_o        = grant;
    inp_ready_o        = '0;
    inp_ready_o[grant] = hs;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      hold_q      <= 1'b0;
      gnt_q       <= '0;
      owner_q     <= '0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          // Freeze the pick while the slave back-pressures.
          hold_q <= oup_valid_o & ~hs;
          if (!hs) gnt_q <= grant;
          if (hs) begin
            if (ARB_MODE == 1) rr_ptr_q <= rr_next;
            if (beats > CNT_W'(1)) begin
              owner_q     <= grant;
              remaining_q <= beats - 1'b1;
            end
          end
        end
        ARB_BURST:
          if (hs) remaining_q <= remaining_q - 1'b1;
        default: ;
      endcase
    end
  end

  a_beats_sat: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(hs && state_q == ARB_IDLE
      && tl_is_data_op(oup_bits_o.opcode)
      && int'(oup_bits_o.size) > SAT_SIZE));

`ifdef TL_BURST_ARB_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (stall_clr_i)
          stall_cnt_o[i] <= '0;
        else if (inp_valid_i[i] && !inp_ready_o[i]
                 && stall_cnt_o[i] != 16'hFFFF)
          stall_cnt_o[i] <= stall_cnt_o[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// Scoreboard bench for tl_burst_arbiter (round-robin and fixed
// priority instances driven by the same master models).
module tb_tl_burst_arbiter;
  import tl_pkg::*;

  typedef struct {
    int m;
    bit lock;
  } ord_t;

  logic             clk, rst, oready, sel;
  logic [3:0]       vin, bubble;
  tl_a_t [3:0]      bin;
  logic [3:0]       rdy0, rdy1, rdy;
  tl_a_t            ob0, ob1, bout;
  logic             ov0, ov1, ovalid;
  logic [1:0]       g0, g1, gidx;
  logic             lk0, lk1, lock;
`ifdef TL_BURST_ARB_STALL_CNT_EN
  logic             stall_clr;
  logic [3:0][15:0] stall0, stall1;
`endif

  tl_a_t mq[4][$];
  tl_a_t rq[4][$];
  ord_t  ord_q[$];
  int    n_chk, n_pass, uid, hs_cnt;
  bit    chk_idle, chk_hold;
  tl_a_t held_b;

  tl_burst_arbiter #(
    .MASTER_NUM(4), .DATA_T(tl_a_t), .BEAT_BYTES(8),
    .MAX_BEATS(16), .ARB_MODE(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst),
    .inp_bits_i(bin), .inp_valid_i(vin),
    .inp_ready_o(rdy0), .oup_bits_o(ob0),
    .oup_valid_o(ov0), .oup_ready_i(oready),
    .grant_idx_o(g0), .burst_lock_o(lk0)
`ifdef TL_BURST_ARB_STALL_CNT_EN
    , .stall_clr_i(stall_clr), .stall_cnt_o(stall0)
`endif
  );

  tl_burst_arbiter #(
    .MASTER_NUM(4), .DATA_T(tl_a_t), .BEAT_BYTES(8),
    .MAX_BEATS(16), .ARB_MODE(1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst),
    .inp_bits_i(bin), .inp_valid_i(vin),
    .inp_ready_o(rdy1), .oup_bits_o(ob1),
    .oup_valid_o(ov1), .oup_ready_i(oready),
    .grant_idx_o(g1), .burst_lock_o(lk1)
`ifdef TL_BURST_ARB_STALL_CNT_EN
    , .stall_clr_i(stall_clr), .stall_cnt_o(stall1)
`endif
  );

  always_comb begin
    rdy    = sel ? rdy1 : rdy0;
    bout   = sel ? ob1 : ob0;
    ovalid = sel ? ov1 : ov0;
    gidx   = sel ? g1 : g0;
    lock   = sel ? lk1 : lk0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  task automatic send(int m, tl_a_op_e op,
                      logic [3:0] sz, int n);
    tl_a_t b;
    for (int k = 0; k < n; k++) begin
      b.opcode = op;
      b.size   = sz;
      b.source = 4'(m);
      b.data   = 16'(uid);
      uid++;
      mq[m].push_back(b);
      rq[m].push_back(b);
    end
  endtask

  task automatic order(int m, int n, bit burst);
    ord_t e;
    for (int k = 0; k < n; k++) begin
      e.m    = m;
      e.lock = burst && (k > 0);
      ord_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      vin[i] = (mq[i].size() > 0) && !bubble[i];
      bin[i] = (mq[i].size() > 0) ? mq[i][0] : '0;
    end
  endtask

  task automatic cycle();
    logic [3:0] rs;
    ord_t       e;
    tl_a_t      x;
    drive();
    @(negedge clk);
    rs = rdy;
    if (chk_idle) begin
      chk("bub_valid", ovalid, 0);
      chk("bub_ready", rdy, 0);
      chk("bub_lock", lock, 1);
    end
    if (chk_hold) begin
      chk("hold_grant", gidx, 3);
      chk("hold_bits", bout, held_b);
    end
    if (ovalid && oready) begin
      hs_cnt++;
      e.m    = 99;
      e.lock = 1'b0;
      if (ord_q.size() > 0) e = ord_q.pop_front();
      chk("grant", gidx, e.m);
      chk("lock", lock, e.lock);
      x = '0;
      if (e.m < 4 && rq[e.m].size() > 0)
        x = rq[e.m].pop_front();
      chk("bits", bout, x);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (rs[i] && mq[i].size() > 0) void'(mq[i].pop_front());
  endtask

  task automatic run(string tag, int budget);
    int n;
    n = 0;
    while (ord_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, ord_q.size(), 0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      rq[i].delete();
    end
    ord_q.delete();
    bubble = '0;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    hs_cnt = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; uid = 1; hs_cnt = 0;
    chk_idle = 0; chk_hold = 0; held_b = '0;
    sel = 1'b1; oready = 1'b1; bubble = '0;
    rst = 1'b1; vin = '0; bin = '0;
`ifdef TL_BURST_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    #1;
    chk("rst_valid", ov1, 0);
    chk("rst_grant", g1, 0);
    chk("rst_lock", lk1, 0);
    chk("rst_ready", rdy1, 0);
    chk("rst_lock0", lk0, 0);
    do_reset();

    // Round-robin over four Get streams.
    send(0, GET, 4'd3, 2); send(1, GET, 4'd3, 2);
    send(2, GET, 4'd3, 2); send(3, GET, 4'd3, 2);
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < 4; m++) order(m, 1, 0);
    repeat (8) cycle();
    chk("rr_drain", ord_q.size(), 0);

    // 8-beat PutFullData from master 2, master 0 waiting.
    do_reset();
    send(2, PUT_FULL_DATA, 4'd6, 8); order(2, 8, 1);
    cycle();
    send(0, GET, 4'd3, 2); order(0, 2, 0);
    repeat (8) cycle();
    chk("burst_c9", ord_q.size(), 1);
    run("burst_drain", 10);

    // Owner bubbles for 3 cycles mid-burst.
    do_reset();
    send(2, PUT_FULL_DATA, 4'd6, 8); order(2, 8, 1);
    cycle();
    send(1, GET, 4'd3, 1); order(1, 1, 0);
    repeat (2) cycle();
    bubble[2] = 1'b1; chk_idle = 1;
    repeat (3) cycle();
    bubble[2] = 1'b0; chk_idle = 0;
    run("bubble_drain", 20);
    chk("bubble_hs", hs_cnt, 9);

    // Back-pressure hold under fixed priority.
    sel = 1'b0;
    do_reset();
    oready = 1'b0;
    send(3, GET, 4'd3, 1); order(3, 1, 0);
    held_b = rq[3][0];
    chk_hold = 1;
    cycle();
    send(0, GET, 4'd3, 1); order(0, 1, 0);
    repeat (4) cycle();
    chk_hold = 0;
    oready = 1'b1;
    run("hold_drain", 10);

    // Single-beat messages regardless of size.
    sel = 1'b1;
    do_reset();
    send(1, GET, 4'd6, 1);
    send(1, PUT_FULL_DATA, 4'd3, 1);
    send(1, ACQUIRE_BLOCK, 4'd6, 1);
    send(1, PUT_PARTIAL_DATA, 4'd2, 1);
    order(1, 4, 0);
    repeat (4) cycle();
    chk("single_drain", ord_q.size(), 0);
    chk("single_lock", lock, 0);

    // Reset in the middle of a burst.
    do_reset();
    send(2, PUT_FULL_DATA, 4'd6, 8); order(2, 8, 1);
    repeat (3) cycle();
    chk("mid_lock", lock, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_lock", lock, 0);
`ifdef TL_BURST_ARB_STALL_CNT_EN
    chk("mid_rst_stall", stall1[0], 0);
`endif
    clear_all();
    @(posedge clk);
    #1 rst = 1'b0;
    send(3, GET, 4'd3, 1); order(3, 1, 0);
    run("post_rst", 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
